// File: rtl/noc_axis_pkg.sv
// Shared definitions for the NoC-to-AXIS egress bridge: control-field
// offsets within a flit, FSM states and the flit width helper.
package noc_axis_pkg;

  // Control bit offsets, relative to the first bit above the payload
  localparam int unsigned LINK_V = 3;
  localparam int unsigned TAIL   = 2;
  localparam int unsigned HEAD   = 1;
  localparam int unsigned VALID  = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  // Full flit width: payload plus the four control bits
  function automatic int unsigned flit_w(input int unsigned data_w);
    return data_w + 4;
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous show-ahead FIFO holding {tlast, data} entries. Pointers carry
// an extra MSB so full and empty are told apart without a separate counter.
// The caller only pushes when there is room (or a pop happens in the same cycle)
// and only pops when the FIFO is not empty.
module noc_flit_fifo #(
  parameter int unsigned W     = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;

  // Pointer update; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + (AW+1)'(1);
      if (pop_i)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q[AW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/noc_to_axis_stream_bridge.sv
// NoC ejection-port to AXI-Stream bridge. Frames incoming flits into AXIS
// packets (tlast on the tail), optionally strips head flits, buffers them in a
// show-ahead FIFO and returns one upstream credit per freed buffer slot.
module noc_to_axis_stream_bridge
  import noc_axis_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DROP_HEAD = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [flit_w(DATA_W)-1:0]   noc_in,
  output logic                        noc_credit,
  output logic                        axis_tvalid,
  input  logic                        axis_tready,
  output logic [DATA_W-1:0]           axis_tdata,
  output logic                        axis_tlast,
  output logic                        err_orphan,
  output logic                        err_nested,
  output logic                        err_overflow,
  output logic [CNT_W-1:0]            pkt_count
);

  // Wide enough to hold DEPTH plus two same-cycle credit events
  localparam int unsigned CW = $clog2(DEPTH) + 2;

  logic [3:0]        ctrl;
  logic              flit_v;
  logic              is_head;
  logic              is_tail;

  state_t            state_q;
  state_t            state_d;

  logic              push_req;
  logic              push_last;
  logic              discard;
  logic              orphan;
  logic              nested;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_rdata;
  logic              overflow;

  logic [CW-1:0]     cred_q;
  logic [CW-1:0]     cred_d;
  logic [CW-1:0]     cred_sum;

  logic              orphan_q;
  logic              nested_q;
  logic              overflow_q;
  logic [CNT_W-1:0]  pkt_q;

  assign ctrl    = noc_in[DATA_W +: 4];
  assign flit_v  = ctrl[LINK_V] & ctrl[VALID];
  assign is_head = ctrl[HEAD];
  assign is_tail = ctrl[TAIL];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: a head always (re)starts a packet, a tail inside one closes it
  always_comb begin
    state_d = state_q;
    if (flit_v) begin
      if (is_head)                          state_d = is_tail ? IDLE : IN_PKT;
      else if (state_q == IN_PKT && is_tail) state_d = IDLE;
    end
  end

  // Flit disposition: push into the buffer, or discard and refund the slot
  always_comb begin
    push_req  = 1'b0;
    push_last = 1'b0;
    discard   = 1'b0;
    orphan    = 1'b0;
    nested    = 1'b0;
    if (flit_v) begin
      if (is_head) begin
        nested = (state_q == IN_PKT);
        if (is_tail) begin
          push_req  = 1'b1;
          push_last = 1'b1;
        end else if (DROP_HEAD != 0) begin
          discard = 1'b1;
        end else begin
          push_req = 1'b1;
        end
      end else if (state_q == IN_PKT) begin
        push_req  = 1'b1;
        push_last = is_tail;
      end else begin
        discard = 1'b1;
        orphan  = 1'b1;
      end
    end
  end

  assign fifo_pop  = ~fifo_empty & axis_tready;
  assign fifo_push = push_req & (~fifo_full | fifo_pop);
  assign overflow  = push_req & fifo_full & ~fifo_pop;

  noc_flit_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i ({push_last, noc_in[DATA_W-1:0]}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Pending credits: add pops and discards, release one per cycle, saturate at DEPTH
  always_comb begin
    cred_sum = cred_q + CW'(fifo_pop) + CW'(discard) - CW'(cred_q != '0);
    cred_d   = (cred_sum > CW'(DEPTH)) ? CW'(DEPTH) : cred_sum;
  end

  // Credit counter register
  always_ff @(posedge clk) begin
    if (rst) cred_q <= '0;
    else     cred_q <= cred_d;
  end

  // Sticky protocol error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      orphan_q   <= 1'b0;
      nested_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (orphan)   orphan_q   <= 1'b1;
      if (nested)   nested_q   <= 1'b1;
      if (overflow) overflow_q <= 1'b1;
    end
  end

  // Completed-packet counter, counts tlast handshakes
  always_ff @(posedge clk) begin
    if (rst)                                pkt_q <= '0;
    else if (fifo_pop && fifo_rdata[DATA_W]) pkt_q <= pkt_q + CNT_W'(1);
  end

  assign noc_credit   = (cred_q != '0);
  assign axis_tvalid  = ~fifo_empty;
  assign axis_tdata   = fifo_empty ? '0 : fifo_rdata[DATA_W-1:0];
  assign axis_tlast   = ~fifo_empty & fifo_rdata[DATA_W];
  assign err_orphan   = orphan_q;
  assign err_nested   = nested_q;
  assign err_overflow = overflow_q;
  assign pkt_count    = pkt_q;

endmodule

// File: tb/tb_noc_to_axis_stream_bridge.sv
// Directed bench for the NoC-to-AXIS bridge: one instance strips heads,
// a second forwards them.
module tb_noc_to_axis_stream_bridge;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW+3:0] noc_in, noc_in0;
  logic          tready, tready0;

  logic          noc_credit, tvalid, tlast, e_orph, e_nest, e_ovf;
  logic [DW-1:0] tdata;
  logic [15:0]   pkt;

  logic          noc_credit0, tvalid0, tlast0, e_orph0, e_nest0, e_ovf0;
  logic [DW-1:0] tdata0;
  logic [15:0]   pkt0;

  always #5 clk = ~clk;

  noc_to_axis_stream_bridge #(
    .DATA_W(DW), .DEPTH(4), .DROP_HEAD(1), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .noc_in(noc_in), .noc_credit(noc_credit),
    .axis_tvalid(tvalid), .axis_tready(tready), .axis_tdata(tdata),
    .axis_tlast(tlast), .err_orphan(e_orph), .err_nested(e_nest),
    .err_overflow(e_ovf), .pkt_count(pkt)
  );

  noc_to_axis_stream_bridge #(
    .DATA_W(DW), .DEPTH(4), .DROP_HEAD(0), .CNT_W(16)
  ) dut0 (
    .clk(clk), .rst(rst), .noc_in(noc_in0), .noc_credit(noc_credit0),
    .axis_tvalid(tvalid0), .axis_tready(tready0), .axis_tdata(tdata0),
    .axis_tlast(tlast0), .err_orphan(e_orph0), .err_nested(e_nest0),
    .err_overflow(e_ovf0), .pkt_count(pkt0)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Handshake / credit monitors, sampled on the falling edge
  logic [DW:0] beats[$];
  int          creds  = 0;
  int          beats0 = 0;
  int          creds0 = 0;
  logic [DW:0] last0  = '0;

  always @(negedge clk) begin
    if (noc_credit === 1'b1) creds++;
    if (tvalid === 1'b1 && tready === 1'b1) beats.push_back({tlast, tdata});
    if (noc_credit0 === 1'b1) creds0++;
    if (tvalid0 === 1'b1 && tready0 === 1'b1) begin
      beats0++;
      last0 = {tlast0, tdata0};
    end
  end

  function automatic logic [DW:0] beat_at(input int i);
    if (i < beats.size()) return beats[i];
    return 'x;
  endfunction

  function automatic logic [DW+3:0] flit(input logic h, input logic t, input logic [DW-1:0] d);
    return {1'b1, t, h, 1'b1, d};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [DW+3:0] f);
    noc_in = f;
    @(posedge clk);
    #1;
    noc_in = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int b0, c0, c1, n0;
    rst = 1'b1; noc_in = '0; noc_in0 = '0; tready = 1'b0; tready0 = 1'b1;
    step(3);
    chk("rst tvalid",  tvalid, 0);
    chk("rst credit",  noc_credit, 0);
    chk("rst tdata",   tdata, 0);
    chk("rst tlast",   tlast, 0);
    chk("rst errs",    {e_orph, e_nest, e_ovf}, 0);
    chk("rst pkt",     pkt, 0);
    chk("rst tvalid0", tvalid0, 0);
    rst = 1'b0;
    step(1);

    // 1: stripped head, body + tail delivered
    tready = 1'b1; b0 = beats.size(); c0 = creds;
    send(flit(1, 0, 32'h0));
    send(flit(0, 0, 32'hA1));
    send(flit(0, 1, 32'hA2));
    step(6);
    chk("t1 nbeats", beats.size() - b0, 2);
    chk("t1 beat0",  beat_at(b0),     {1'b0, 32'hA1});
    chk("t1 beat1",  beat_at(b0 + 1), {1'b1, 32'hA2});
    chk("t1 creds",  creds - c0, 3);
    chk("t1 pkt",    pkt, 1);

    // 2: single head&tail flit on the head-forwarding instance
    c0 = creds0; n0 = beats0;
    chk("t2 pre tvalid", tvalid0, 0);
    noc_in0 = flit(1, 1, 32'h55);
    @(posedge clk); #1;
    noc_in0 = '0;
    chk("t2 tvalid", tvalid0, 1);
    chk("t2 tdata",  tdata0, 32'h55);
    chk("t2 tlast",  tlast0, 1);
    step(4);
    chk("t2 nbeats", beats0 - n0, 1);
    chk("t2 beat",   last0, {1'b1, 32'h55});
    chk("t2 creds",  creds0 - c0, 1);
    chk("t2 pkt",    pkt0, 1);

    // 5: push+pop while full, then head strip coinciding with a pop
    tready = 1'b0; b0 = beats.size();
    send(flit(1, 0, 32'h0));
    for (int i = 0; i < 4; i++) send(flit(0, 0, 32'h40 + i));
    step(3);
    chk("t5 full tvalid", tvalid, 1);
    chk("t5 full tdata",  tdata, 32'h40);
    tready = 1'b1; noc_in = flit(0, 1, 32'h44);
    @(posedge clk); #1;
    tready = 1'b0; noc_in = '0;
    chk("t5 no ovf",   e_ovf, 0);
    chk("t5 head",     tdata, 32'h41);
    step(2);
    c1 = creds;
    tready = 1'b1; noc_in = flit(1, 0, 32'h0);
    @(posedge clk); #1;
    tready = 1'b0; noc_in = '0;
    chk("t5 cred c1", noc_credit, 1);
    step(1);
    chk("t5 cred c2", noc_credit, 1);
    step(1);
    chk("t5 cred c3", noc_credit, 0);
    chk("t5 creds",   creds - c1, 2);
    tready = 1'b1;
    step(6);
    send(flit(0, 1, 32'h47));
    step(4);
    chk("t5 nbeats", beats.size() - b0, 6);
    for (int i = 0; i < 4; i++) chk("t5 body", beat_at(b0 + i), {1'b0, 32'h40 + i});
    chk("t5 beat4",  beat_at(b0 + 4), {1'b1, 32'h44});
    chk("t5 beat5",  beat_at(b0 + 5), {1'b1, 32'h47});
    chk("t5 ovf",    e_ovf, 0);
    chk("t5 nested", e_nest, 0);
    chk("t5 pkt",    pkt, 3);

    // 4: orphan tail, then nested head
    b0 = beats.size(); c0 = creds;
    send(flit(0, 1, 32'h77));
    step(3);
    chk("t4 no beat", beats.size() - b0, 0);
    chk("t4 orphan",  e_orph, 1);
    chk("t4 creds",   creds - c0, 1);
    b0 = beats.size(); c0 = creds;
    send(flit(1, 0, 32'h0));
    chk("t4 no nest", e_nest, 0);
    send(flit(1, 0, 32'h0));
    chk("t4 nested",  e_nest, 1);
    send(flit(0, 0, 32'h31));
    send(flit(0, 1, 32'h32));
    step(6);
    chk("t4 nbeats", beats.size() - b0, 2);
    chk("t4 beat0",  beat_at(b0),     {1'b0, 32'h31});
    chk("t4 beat1",  beat_at(b0 + 1), {1'b1, 32'h32});
    chk("t4 creds2", creds - c0, 4);
    chk("t4 pkt",    pkt, 4);

    // 3: backpressure, overflow, release
    tready = 1'b0;
    send(flit(1, 0, 32'h0));
    for (int i = 0; i < 4; i++) send(flit(0, 0, 32'h10 + i));
    chk("t3 tvalid", tvalid, 1);
    chk("t3 tdata",  tdata, 32'h10);
    chk("t3 no ovf", e_ovf, 0);
    step(2);
    c0 = creds; b0 = beats.size();
    send(flit(0, 0, 32'h14));
    chk("t3 ovf",    e_ovf, 1);
    step(3);
    chk("t3 stable", {tvalid, tlast, tdata}, {1'b1, 1'b0, 32'h10});
    tready = 1'b1;
    step(8);
    chk("t3 nbeats", beats.size() - b0, 4);
    for (int i = 0; i < 4; i++) chk("t3 beat", beat_at(b0 + i), {1'b0, 32'h10 + i});
    chk("t3 creds",  creds - c0, 4);
    send(flit(0, 1, 32'h15));
    step(4);
    chk("t3 pkt",    pkt, 5);

    // 6: reset mid-packet with buffered flits
    tready = 1'b0;
    send(flit(1, 0, 32'h0));
    send(flit(0, 0, 32'h60));
    send(flit(0, 0, 32'h61));
    step(1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    c0 = creds;
    chk("t6 tvalid", tvalid, 0);
    chk("t6 credit", noc_credit, 0);
    chk("t6 errs",   {e_orph, e_nest, e_ovf}, 0);
    chk("t6 pkt",    pkt, 0);
    step(3);
    chk("t6 no cred", creds - c0, 0);
    b0 = beats.size(); c0 = creds; tready = 1'b1;
    send(flit(1, 0, 32'h0));
    send(flit(0, 1, 32'h62));
    step(6);
    chk("t6 nbeats", beats.size() - b0, 1);
    chk("t6 beat",   beat_at(b0), {1'b1, 32'h62});
    chk("t6 creds",  creds - c0, 2);
    chk("t6 pkt2",   pkt, 1);
    chk("t6 errs2",  {e_orph, e_nest, e_ovf}, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
